cic_interpolator: RTL and testbench
===================================

# cic_interpolator

Cascaded integrator-comb interpolator for the transmit path, the rate-raising counterpart of the receive decimator. It accepts low-rate I or Q samples, runs the comb section at the input rate, and zero-stuffs by a runtime-selectable factor R. It then runs the integrator section at the high rate and delivers rounded, saturated samples to the DAC-side chain. The high-rate consumer paces the block: it pulses `out_strobe`, and the block requests input via `in_strobe`.

## Interface

**Parameters**
- `STAGES`, 5: number of comb sections, equal to the number of integrator sections.
- `MIN_INTERPOLATION`, 2: smallest legal R. Must be ≥ 2. If equal to `MAX_INTERPOLATION`, the block is fixed-rate and ignores `interpolation`.
- `MAX_INTERPOLATION`, 40: largest legal R.
- `IN_WIDTH`, 18: width of the signed input.
- `OUT_WIDTH`, 18: width of the signed output.
- `ACC_WIDTH`, IN_WIDTH + STAGES·$clog2(MAX_INTERPOLATION): derived width of every comb and integrator register.

**Ports**
- `clock`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `interpolation`, in, $clog2(MAX_INTERPOLATION)+1: R, valid range MIN..MAX.
- `out_strobe`, in, 1: high-rate tick; one output sample is produced per pulse.
- `in_strobe`, out, 1: one-cycle pulse; `in_data` is sampled in this cycle.
- `in_data`, in, IN_WIDTH, signed: held stable by upstream until `in_strobe`.
- `out_valid`, out, 1: one-cycle pulse marking a new `out_data`.
- `out_data`, out, OUT_WIDTH, signed: registered output.

## Operation

**Phase counter**
- `phase` has width $clog2(MAX_INTERPOLATION) and counts `out_strobe` pulses.
- On `out_strobe`: if `phase ≥ R−1`, set `phase` to 0 and set `in_strobe` to 1 on the next cycle. Otherwise increment `phase`.
- The `≥` compare means a decrease in R mid-frame wraps at once.
- R is read live; it has no shadow register.

**Comb section** (runs in the `in_strobe` cycle)
- `comb[1] <= in_data − last[0]`, and `last[0] <= in_data`, where `in_data` is sign-extended to ACC_WIDTH.
- `comb[k+1] <= comb[k] − last[k]`, and `last[k] <= comb[k]`.
- The combs form a pipeline, so output latency is STAGES input samples.

**Integrator section** (runs in the `out_strobe` cycle)
- `integ[1] <= integ[1] + x`.
  - x = `comb[STAGES]`, as registered at the start of the cycle, when `phase == 0`.
  - x = 0 otherwise (zero-stuffing).
- `integ[k+1] <= integ[k+1] + integ[k]`, using old values.
- Two's-complement wraparound inside the integrators is intended and harmless.

**Output scaling**
- Gain is R^(STAGES−1).
- msb = IN_WIDTH + (STAGES−1)·$clog2(R) − 1.
- Result = `integ[STAGES][msb -: OUT_WIDTH]` plus bit `[msb−OUT_WIDTH]`, which rounds half-up.
- If the rounding add overflows past +max, saturate to 2^(OUT_WIDTH−1)−1.
- Non-power-of-2 R yields gain below unity; this is accepted.

**Reset**
- Reset clears `phase`, all combs, all `last` registers and all integrators.
- `out_data` = 0, `out_valid` = 0, `in_strobe` = 0.
- Reset takes priority over both strobes.

## Timing

- `out_valid` and the updated `out_data` appear 1 clock after the `out_strobe` that produced them.
- `in_strobe` appears 1 clock after the R-th `out_strobe` of a frame.
- `out_strobe` may be asserted every cycle. When it coincides with `in_strobe`, both sections update in that same cycle.
  - The integrator uses the pre-update comb value. This is deterministic and adds no special case.
- The first `in_strobe` after reset occurs after R `out_strobe` pulses. Until then the integrators see zero input.
- When `reset` deasserts, the first `out_strobe` counts as phase 0.

## Structure

- Shared package `cic_pkg` holds:
  - the width-derivation function acc_width(in_w, stages, max_r);
  - the msb-position function.
- The decimator uses the same package.
- One sub-module, `cic_round_sat`, is combinational. It takes the accumulator, msb and OUT_WIDTH, and returns the rounded, saturated word.
- Everything else is flat in `cic_interpolator`.

## Test plan

All scenarios use STAGES=5, IN_WIDTH=OUT_WIDTH=18 and R=8 unless stated otherwise.

1. **Strobe cadence.** Send 80 `out_strobe` pulses, one every 4 cycles → exactly 10 `in_strobe` pulses, each 1 cycle after strobes 8, 16, … 80. `out_valid` follows each `out_strobe` by 1 cycle.
2. **DC gain.** Drive `in_data` = 1000 constant → `out_data` settles to exactly 1000 and stays there. Repeat with R=5 → settles to 153 (1000·625/4096, rounded).
3. **Impulse response.** One input of 4096, then zeros → 36 nonzero outputs (5·7+1), symmetric, summing to 32768. All zeros afterwards.
4. **Full scale.** DC input of +131071 → output 131071 with no wrap. DC input of −131072 → output −131072.
5. **Rate change mid-frame.** With R=8 and `phase` at 6, switch to R=4 → wrap on the next `out_strobe`, then `in_strobe` every 4th strobe. Output recovers to the DC value with no X or stuck state.
6. **Reset mid-operation.** Assert `reset` for 1 cycle while DC is applied, coinciding with `out_strobe` → next cycle `out_data`=0, `out_valid`=0, `in_strobe`=0. The first `in_strobe` after reset comes after exactly 8 `out_strobe` pulses.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared CIC helpers: accumulator width derivation and output-field msb position.
// Used by both the transmit interpolator and the receive decimator.
package cic_pkg;

  // Ceiling log2, usable both at elaboration time and on a live rate value.
  function automatic int clog2_int(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int acc_width(input int in_w, input int stages, input int max_r);
    return in_w + stages * clog2_int(max_r);
  endfunction

  function automatic int msb_pos(input int in_w, input int stages, input int r);
    return in_w + (stages - 1) * clog2_int(r) - 1;
  endfunction

endpackage

// File: rtl/cic_round_sat.sv
// Extracts OUT_WIDTH bits ending at a runtime msb, rounds half-up on the next bit
// and clamps the single overflow case the rounding add can create.
module cic_round_sat #(
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 18,
  parameter int MSB_WIDTH = 6
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  input  logic        [MSB_WIDTH-1:0] i_msb,
  output logic signed [OUT_WIDTH-1:0] o_data
);

  localparam logic signed [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  logic signed [OUT_WIDTH-1:0] w_trunc;
  logic                        w_round;

  always_comb begin
    w_trunc = OUT_WIDTH'(i_acc >>> (i_msb - MSB_WIDTH'(OUT_WIDTH - 1)));
    w_round = (i_msb >= MSB_WIDTH'(OUT_WIDTH)) ? i_acc[i_msb - MSB_WIDTH'(OUT_WIDTH)] : 1'b0;
    if (w_round && (w_trunc == MAX_POS))
      o_data = MAX_POS;
    else
      o_data = w_trunc + $signed({{(OUT_WIDTH-1){1'b0}}, w_round});
  end

endmodule

// File: rtl/cic_interpolator.sv
// Transmit-path CIC interpolator: combs at the input rate, zero-stuffing by a live
// factor R, integrators at the out_strobe rate, rounded/saturated registered output.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int STAGES            = 5,
  parameter int MIN_INTERPOLATION = 2,
  parameter int MAX_INTERPOLATION = 40,
  parameter int IN_WIDTH          = 18,
  parameter int OUT_WIDTH         = 18
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [$clog2(MAX_INTERPOLATION):0]   interpolation,
  input  logic                                 out_strobe,
  output logic                                 in_strobe,
  input  logic signed [IN_WIDTH-1:0]           in_data,
  output logic                                 out_valid,
  output logic signed [OUT_WIDTH-1:0]          out_data
);

  localparam int ACC_WIDTH = acc_width(IN_WIDTH, STAGES, MAX_INTERPOLATION);
  localparam int PH_W      = $clog2(MAX_INTERPOLATION);
  localparam int R_W       = PH_W + 1;
  localparam int MSB_W     = $clog2(ACC_WIDTH);

  logic [R_W-1:0]              w_r;
  logic                        w_wrap;
  logic [MSB_W-1:0]            w_msb;
  logic signed [ACC_WIDTH-1:0] w_in_ext;
  logic signed [ACC_WIDTH-1:0] w_integ_next [1:STAGES];
  logic signed [OUT_WIDTH-1:0] w_rounded;

  logic [PH_W-1:0]             r_phase;
  logic signed [ACC_WIDTH-1:0] r_comb  [1:STAGES];
  logic signed [ACC_WIDTH-1:0] r_last  [0:STAGES-1];
  logic signed [ACC_WIDTH-1:0] r_integ [1:STAGES];

  // Out-of-range R is clamped so the phase compare can never underflow.
  always_comb begin
    if (MIN_INTERPOLATION == MAX_INTERPOLATION)
      w_r = R_W'(MAX_INTERPOLATION);
    else if (interpolation < R_W'(MIN_INTERPOLATION))
      w_r = R_W'(MIN_INTERPOLATION);
    else if (interpolation > R_W'(MAX_INTERPOLATION))
      w_r = R_W'(MAX_INTERPOLATION);
    else
      w_r = interpolation;
  end

  assign w_wrap   = ({1'b0, r_phase} >= (w_r - R_W'(1)));
  assign w_msb    = MSB_W'(msb_pos(IN_WIDTH, STAGES, int'(w_r)));
  assign w_in_ext = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

  // Integrator chain uses old values throughout; only phase 0 injects the comb output.
  always_comb begin
    w_integ_next[1] = r_integ[1] + ((r_phase == '0) ? r_comb[STAGES] : '0);
    for (int k = 1; k < STAGES; k++)
      w_integ_next[k+1] = r_integ[k+1] + r_integ[k];
  end

  cic_round_sat #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .MSB_WIDTH(MSB_W)
  ) u_round_sat (
    .i_acc (w_integ_next[STAGES]),
    .i_msb (w_msb),
    .o_data(w_rounded)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase   <= '0;
      in_strobe <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        r_comb[k]   <= '0;
        r_last[k-1] <= '0;
        r_integ[k]  <= '0;
      end
    end else begin
      in_strobe <= 1'b0;
      out_valid <= out_strobe;
      if (out_strobe) begin
        if (w_wrap) begin
          r_phase   <= '0;
          in_strobe <= 1'b1;
        end else begin
          r_phase <= r_phase + PH_W'(1);
        end
        for (int k = 1; k <= STAGES; k++)
          r_integ[k] <= w_integ_next[k];
        out_data <= w_rounded;
      end
      if (in_strobe) begin
        r_comb[1] <= w_in_ext - r_last[0];
        r_last[0] <= w_in_ext;
        for (int k = 1; k < STAGES; k++) begin
          r_comb[k+1] <= r_comb[k] - r_last[k];
          r_last[k]   <= r_comb[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed and randomized checks of cic_interpolator against a closed-form model:
// binomial comb differences, zero-stuffed frames and C(n,STAGES-1) integrator response.
module tb_cic_interpolator;

  localparam int STAGES = 5;
  localparam int IN_W   = 18;
  localparam int OUT_W  = 18;
  localparam int MINR   = 2;
  localparam int MAXR   = 40;
  localparam longint MAXP = 131071;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [6:0]              interpolation;
  logic                    out_strobe;
  logic                    in_strobe;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;

  cic_interpolator #(
    .STAGES(STAGES), .MIN_INTERPOLATION(MINR), .MAX_INTERPOLATION(MAXR),
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)
  ) dut (
    .clock(clock), .reset(reset), .interpolation(interpolation),
    .out_strobe(out_strobe), .in_strobe(in_strobe), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int     m_phase;
  bit     m_pend;
  int     m_j;
  int     frame_start[$];
  longint d_hist[$];
  longint exp_out;
  bit     exp_in, exp_valid;

  // stimulus source
  int     mode;      // 0 DC, 1 impulse, 2 random
  longint dc_val;
  int     out_log[$];
  int     dut_in_cnt;

  function automatic int tb_clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    if (n < k || n < 0) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint dval(input int i);
    if (i < 0 || i >= d_hist.size()) return 0;
    return d_hist[i];
  endfunction

  // STAGES-th difference of the low-rate input sequence
  function automatic longint comb_out(input int n);
    longint s = 0;
    for (int k = 0; k <= STAGES; k++)
      s += ((k % 2) ? -1 : 1) * binom(STAGES, k) * dval(n - k);
    return s;
  endfunction

  function automatic longint raw_out(input int j);
    longint s = 0;
    for (int q = 0; q < frame_start.size(); q++)
      s += comb_out(q - STAGES) * binom(j - frame_start[q], STAGES - 1);
    return s;
  endfunction

  function automatic longint wrap18(input longint v);
    longint m = v & 64'h3FFFF;
    if (m >= 131072) m -= 262144;
    return m;
  endfunction

  function automatic longint scale(input longint y, input int r);
    int     sh = IN_W + (STAGES - 1) * tb_clog2(r) - 1 - (OUT_W - 1);
    longint t  = wrap18(y >>> sh);
    longint rb = (y >>> (sh - 1)) & 1;
    if (rb == 1 && t == MAXP) return MAXP;
    return wrap18(t + rb);
  endfunction

  function automatic logic signed [IN_W-1:0] gen_sample(input int idx);
    logic [IN_W-1:0] t;
    case (mode)
      0:       return IN_W'(dc_val);
      1:       return (idx == 0) ? 18'sd4096 : 18'sd0;
      default: begin t = IN_W'($urandom); return $signed(t); end
    endcase
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input bit s, input bit rst);
    bit nxt, captured;
    int r;
    nxt = 0; captured = 0;
    out_strobe = s;
    reset = rst;
    @(posedge clock);
    if (rst) begin
      m_phase = 0; m_pend = 0; m_j = 0;
      frame_start.delete(); d_hist.delete();
      exp_in = 0; exp_valid = 0; exp_out = 0;
    end else begin
      if (m_pend) begin
        d_hist.push_back(longint'(in_data));
        captured = 1;
      end
      if (s) begin
        r = int'(interpolation);
        if (m_phase == 0) frame_start.push_back(m_j);
        if (m_phase >= r - 1) begin m_phase = 0; nxt = 1; end
        else m_phase++;
        exp_out = scale(raw_out(m_j), r);
        exp_valid = 1;
        m_j++;
      end else begin
        exp_valid = 0;
      end
      m_pend = nxt;
      exp_in = nxt;
    end
    #1;
    if (rst) in_data = gen_sample(0);
    else if (captured) in_data = gen_sample(d_hist.size());
    chk("in_strobe", in_strobe, exp_in);
    chk("out_valid", out_valid, exp_valid);
    chk("out_data", out_data, exp_out);
    if (in_strobe === 1'b1) dut_in_cnt++;
    if (out_valid === 1'b1) out_log.push_back(int'(out_data));
    out_strobe = 0;
  endtask

  task automatic strobes(input int n, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) begin
      tick(1, 0);
      repeat ($urandom_range(gmax, gmin)) tick(0, 0);
    end
  endtask

  task automatic seg_reset(input int r, input int md, input longint dc);
    interpolation = 7'(r);
    mode = md;
    dc_val = dc;
    tick(0, 1);
    tick(0, 0);
    out_log.delete();
    dut_in_cnt = 0;
  endtask

  task automatic chk_tail(input string tag, input int n, input int val);
    for (int i = 0; i < n; i++) chk(tag, out_log[out_log.size() - 1 - i], val);
  endtask

  initial begin
    int first, last, nz, sum, asym, cnt;
    bit seen;
    reset = 1; out_strobe = 0; in_data = 0; interpolation = 7'd8;
    mode = 0; dc_val = 1000; dut_in_cnt = 0;

    // reset state
    tick(0, 1);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_strobe", in_strobe, 0);

    // strobe cadence: 80 strobes, one every 4 cycles
    seg_reset(8, 0, 1000);
    strobes(80, 3, 3);
    chk("cadence_in_strobe_count", dut_in_cnt, 10);

    // DC gain at R=8 and R=5
    strobes(80, 1, 3);
    chk_tail("dc_r8", 16, 1000);
    seg_reset(5, 0, 1000);
    strobes(100, 1, 3);
    chk_tail("dc_r5", 10, 153);

    // impulse response
    seg_reset(8, 1, 0);
    strobes(120, 1, 3);
    first = -1; last = -1; nz = 0; sum = 0; asym = 0;
    for (int i = 0; i < out_log.size(); i++) begin
      if (out_log[i] != 0) begin
        if (first < 0) first = i;
        last = i; nz++; sum += out_log[i];
      end
    end
    chk("impulse_nonzero", nz, 36);
    chk("impulse_span", last - first + 1, 36);
    chk("impulse_sum", sum, 32768);
    for (int i = 0; i < 18 && first >= 0; i++)
      if (out_log[first + i] != out_log[last - i]) asym++;
    chk("impulse_symmetry", asym, 0);
    chk("impulse_tail_zero", out_log[out_log.size() - 1], 0);

    // full scale
    seg_reset(8, 0, 131071);
    strobes(100, 1, 3);
    chk_tail("full_pos", 8, 131071);
    seg_reset(8, 0, -131072);
    strobes(100, 1, 3);
    chk_tail("full_neg", 8, -131072);

    // rate change mid-frame: R 8 -> 4 with phase at 6
    seg_reset(8, 0, 1000);
    strobes(70, 1, 2);
    for (int g = 0; g < 16 && m_phase != 6; g++) strobes(1, 1, 2);
    chk("rate_phase_reached", m_phase, 6);
    interpolation = 7'd4;
    dut_in_cnt = 0;
    strobes(40, 1, 3);
    chk("rate_in_strobe_count", dut_in_cnt, 10);
    chk("rate_no_x", $isunknown(out_data), 0);

    // reset coinciding with out_strobe
    interpolation = 7'd8;
    strobes(30, 1, 2);
    tick(1, 1);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_strobe", in_strobe, 0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1, 0);
      cnt++;
      if (in_strobe === 1'b1) seen = 1;
      tick(0, 0);
    end
    chk("midrst_first_in_strobe", cnt, 8);

    // randomized data at random rates
    for (int it = 0; it < 3; it++) begin
      seg_reset(int'($urandom_range(MAXR, MINR)), 2, 0);
      strobes((STAGES + 4) * int'(interpolation), 1, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
